dl_mem_arbiter: RTL and testbench
=================================

DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 The parameter ROM_AW SHALL default to 16 and set the ROM address width (ROM size is 2^ROM_AW bytes).
REQ-002 The parameter HOLD_CYCLES SHALL default to 16 and set the post-download CPU reset stretch, in clk_sys cycles.
REQ-003 Port clk_sys  in  1  is the single system clock; all logic is clocked on its rising edge.
REQ-004 Port reset  in  1  is an asynchronous, active-high reset.
REQ-005 Ports ioctl_download, ioctl_wr  in  1 each  carry the HPS download-active level and the write strobe.
REQ-006 Ports ioctl_addr  in  25, ioctl_dout  in  8, ioctl_index  in  8  carry the HPS write address, data and index.
REQ-007 Port ioctl_wait  out  1  is the back-pressure to the HPS: no new ioctl_wr is issued while it is high.
REQ-008 Ports cpu_addr  in  16, cpu_wdata  in  8, cpu_we  in  1  are the CPU memory-port request.
REQ-009 Ports mem_addr  out  16, mem_wdata  out  8, mem_we  out  1  drive the shared memory port.
REQ-010 Port cpu_reset  out  1  is high while the CPU must be held in reset.
REQ-011 Ports mod  out  8 and sw0/sw1/sw2  out  8 each  are the game-select and DIP registers.
REQ-012 Port dl_count  out  ROM_AW+1  is the number of committed ROM bytes.
REQ-013 Ports err_oversize and err_overrun  out  1 each  are sticky error flags.

Function
REQ-014 The state machine SHALL have three states: RUN, LOAD and HOLD.
REQ-015 In RUN, mem_addr, mem_wdata and mem_we SHALL equal cpu_addr, cpu_wdata and cpu_we combinationally, and cpu_reset SHALL be 0.
REQ-016 In LOAD and HOLD, the memory port SHALL be driven only by the write buffer, mem_we SHALL be 0 except on a ROM commit, and cpu_reset SHALL be 1.
REQ-017 RUN or HOLD SHALL go to LOAD on the first cycle ioctl_download is sampled high; entering LOAD SHALL clear dl_count, err_oversize and err_overrun.
REQ-018 LOAD SHALL go to HOLD when ioctl_download is low and the write buffer is empty, loading the hold counter with HOLD_CYCLES-1.
REQ-019 HOLD SHALL decrement the counter each cycle and go to RUN in the cycle after the counter reads 0, giving exactly HOLD_CYCLES HOLD cycles.
REQ-020 An ioctl_wr with the buffer empty SHALL capture index, addr and data into a one-entry buffer and raise ioctl_wait in the next cycle.
REQ-021 The buffered write SHALL commit in the cycle after capture, and the buffer and ioctl_wait SHALL clear in that same cycle (ioctl_wait is high for exactly 1 cycle per write).
REQ-022 A commit with index 0 and addr < 2^ROM_AW, in LOAD, SHALL drive mem_addr=addr[15:0], mem_wdata=data and mem_we=1 for one cycle, and SHALL increment dl_count (saturating).
REQ-023 A commit with index 0 and addr >= 2^ROM_AW SHALL be dropped and SHALL set err_oversize; index-0 commits outside LOAD SHALL be dropped silently.
REQ-024 A commit with index 1 and addr 0 SHALL load mod; with index 254 and addr 0..2 it SHALL load sw0..sw2; these are accepted in any state.
REQ-025 All other index/address combinations SHALL be discarded with no side effect.
REQ-026 An ioctl_wr arriving while the buffer is full SHALL be dropped and SHALL set err_overrun.
REQ-027 ioctl_download falling while the buffer is full SHALL delay the LOAD-to-HOLD transition until the commit has happened.

Reset
REQ-028 While reset is high, the state SHALL be HOLD, the hold counter HOLD_CYCLES-1, cpu_reset 1, and the buffer empty.
REQ-029 While reset is high, ioctl_wait, mem_we, dl_count and both error flags SHALL be 0, mod SHALL be 0 and sw0..sw2 SHALL be 8'hFF.
REQ-030 A reset asserted mid-LOAD SHALL abort the download; the pending buffered write SHALL be lost and SHALL NOT commit.

Structure
REQ-031 A shared package SHALL hold the state enum and the constants IDX_ROM=0, IDX_MOD=1 and IDX_DIP=254.
REQ-032 The design SHALL be a single module with no sub-modules; the write buffer and the hold counter are inline.

Verification
REQ-033 Release reset with ioctl_download=0 -> cpu_reset stays 1 for 16 cycles, then RUN and port passthrough of cpu_addr=16'h1234, cpu_we=1.
REQ-034 Download index 0 of bytes 0xC3,0x00,0x10 at addr 0..2 -> three mem_we pulses at addr 0..2, ioctl_wait pulses of 1 cycle each, dl_count=3.
REQ-035 Index 0 write at addr 25'h10000 -> no mem_we, err_oversize=1; the next download start clears it.
REQ-036 Index 254 writes 0x80,0x01,0x7F at addr 0..2 during RUN -> sw0..sw2 updated, cpu_reset stays 0, the port stays with the CPU.
REQ-037 ioctl_wr on two consecutive cycles -> the second write is dropped and err_overrun=1.
REQ-038 Reset pulse in LOAD with a write buffered -> no mem_we, state HOLD, 16 cycles of cpu_reset, then RUN.

Source files
------------

// File: rtl/dl_mem_arbiter_pkg.sv
// Shared types and constants for the HPS download / CPU memory-port arbiter.
// The ioctl index values select the target of an HPS write.
package dl_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // DIP writes use byte addresses 0..2, one per switch bank.
    localparam int DIP_BANKS = 3;

endpackage

// File: rtl/dl_mem_arbiter.sv
// Arbitrates the shared memory port between the CPU and HPS ROM download,
// holds the CPU in reset during and after a download, and decodes DIP/mod writes.
//
// state | meaning
// RUN   | CPU owns the memory port, cpu_reset low
// LOAD  | HPS download active, ROM bytes committed from the write buffer
// HOLD  | download done, CPU reset stretched for HOLD_CYCLES cycles
module dl_mem_arbiter
    import dl_mem_arbiter_pkg::*;
#(
    parameter int ROM_AW      = 16,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,

    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,

    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_we,

    output logic [15:0]       mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,

    output logic              cpu_reset,
    output logic [7:0]        mod,
    output logic [7:0]        sw0,
    output logic [7:0]        sw1,
    output logic [7:0]        sw2,
    output logic [ROM_AW:0]   dl_count,
    output logic              err_oversize,
    output logic              err_overrun
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ROM_AW:0]  COUNT_MAX   = {(ROM_AW+1){1'b1}};

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] hold_cnt;

    logic             buf_valid;
    logic [7:0]       buf_index;
    logic [24:0]      buf_addr;
    logic [7:0]       buf_data;

    logic             enter_load;
    logic             rom_in_range;
    logic             rom_commit;
    logic             rom_oversize;
    logic             mod_commit;
    logic             dip_commit;
    logic             wr_accept;
    logic             wr_overrun;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (ioctl_download)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // A write still sitting in the buffer must commit as ROM data first.
                if (!ioctl_download && !buf_valid)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (ioctl_download)
                    state_nxt = ST_LOAD;
                else if (hold_cnt == '0)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    assign enter_load = (state != ST_LOAD) && (state_nxt == ST_LOAD);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_RELOAD;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD && state_nxt == ST_HOLD)
                hold_cnt <= HOLD_RELOAD;
            else if (state == ST_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // One-entry write buffer: capture on ioctl_wr, commit next cycle
    // ------------------------------------------------------------------
    assign wr_accept  = ioctl_wr && !buf_valid;
    assign wr_overrun = ioctl_wr &&  buf_valid;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_index <= '0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            buf_valid <= wr_accept;
            if (wr_accept) begin
                buf_index <= ioctl_index;
                buf_addr  <= ioctl_addr;
                buf_data  <= ioctl_dout;
            end
        end
    end

    assign ioctl_wait = buf_valid;

    // ------------------------------------------------------------------
    // Commit decode
    // ------------------------------------------------------------------
    assign rom_in_range = ((buf_addr >> ROM_AW) == 25'd0);

    always_comb begin
        rom_commit   = 1'b0;
        rom_oversize = 1'b0;
        mod_commit   = 1'b0;
        dip_commit   = 1'b0;
        if (buf_valid) begin
            if (buf_index == IDX_ROM && state == ST_LOAD) begin
                rom_commit   = rom_in_range;
                rom_oversize = !rom_in_range;
            end
            if (buf_index == IDX_MOD && buf_addr == 25'd0)
                mod_commit = 1'b1;
            if (buf_index == IDX_DIP && buf_addr < 25'(DIP_BANKS))
                dip_commit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux and CPU reset
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = buf_addr[15:0];
        mem_wdata = buf_data;
        mem_we    = rom_commit;
        cpu_reset = 1'b1;
        if (state == ST_RUN) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            cpu_reset = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Download bookkeeping and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_count     <= '0;
            err_oversize <= 1'b0;
            err_overrun  <= 1'b0;
        end else if (enter_load) begin
            dl_count     <= '0;
            err_oversize <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (rom_commit && dl_count != COUNT_MAX)
                dl_count <= dl_count + 1'b1;
            if (rom_oversize)
                err_oversize <= 1'b1;
            if (wr_overrun)
                err_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Game-select and DIP registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mod <= 8'h00;
            sw0 <= 8'hFF;
            sw1 <= 8'hFF;
            sw2 <= 8'hFF;
        end else begin
            if (mod_commit)
                mod <= buf_data;
            if (dip_commit) begin
                case (buf_addr[1:0])
                    2'd0:    sw0 <= buf_data;
                    2'd1:    sw1 <= buf_data;
                    default: sw2 <= buf_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Directed self-checking bench for dl_mem_arbiter: reset stretch, ROM download,
// oversize/overrun errors, DIP writes in RUN, delayed HOLD entry and mid-LOAD reset.
module tb_dl_mem_arbiter;

    localparam int HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_reset;
    logic [7:0]  mod, sw0, sw1, sw2;
    logic [16:0] dl_count;
    logic        err_oversize, err_overrun;

    int n_cmp = 0;
    int n_err = 0;

    dl_mem_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cpu_reset(cpu_reset), .mod(mod), .sw0(sw0), .sw1(sw1), .sw2(sw2),
        .dl_count(dl_count), .err_oversize(err_oversize), .err_overrun(err_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Counts cycles with cpu_reset high until RUN, bounded.
    task automatic wait_run(output int n, output bit saw_we);
        n = 0;
        saw_we = 1'b0;
        while (cpu_reset === 1'b1 && n < 100) begin
            if (mem_we === 1'b1) saw_we = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic hps_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n; bit saw;
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (ioctl_wait !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rst_wait_we: got %b%b want 00", ioctl_wait, mem_we); end
        n_cmp++; if (dl_count !== 17'd0 || err_oversize !== 1'b0 || err_overrun !== 1'b0) begin n_err++; $display("FAIL rst_count_err: got %0d %b %b want 0 0 0", dl_count, err_oversize, err_overrun); end
        n_cmp++; if ({mod, sw0, sw1, sw2} !== 32'h00FF_FFFF) begin n_err++; $display("FAIL rst_regs: got %h want 00ffffff", {mod, sw0, sw1, sw2}); end
        reset = 1'b0;
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD) begin n_err++; $display("FAIL rst_hold_len: got %0d want %0d", n, HOLD); end
        cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        #1;
        n_cmp++; if ({mem_addr, mem_wdata, mem_we} !== {16'h1234, 8'h5A, 1'b1}) begin n_err++; $display("FAIL run_passthrough: got %h %h %b want 1234 5a 1", mem_addr, mem_wdata, mem_we); end
    endtask

    task automatic test_download();
        logic [7:0] d [3];
        int n; bit saw;
        d[0] = 8'hC3; d[1] = 8'h00; d[2] = 8'h10;
        ioctl_download = 1'b1;
        tick();
        n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL dl_cpu_reset: got %b want 1", cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            ioctl_index = 8'd0; ioctl_addr = 25'(i); ioctl_dout = d[i]; ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
            n_cmp++; if ({ioctl_wait, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'(i), d[i]})
                begin n_err++; $display("FAIL dl_commit%0d: got wait=%b we=%b %h %h want 1 1 %h %h", i, ioctl_wait, mem_we, mem_addr, mem_wdata, 16'(i), d[i]); end
            tick();
            n_cmp++; if ({ioctl_wait, mem_we} !== 2'b00) begin n_err++; $display("FAIL dl_idle%0d: got wait=%b we=%b want 0 0", i, ioctl_wait, mem_we); end
        end
        n_cmp++; if (dl_count !== 17'd3) begin n_err++; $display("FAIL dl_count: got %0d want 3", dl_count); end
        ioctl_download = 1'b0;
        tick();
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD || saw !== 1'b0) begin n_err++; $display("FAIL dl_hold: got %0d we=%b want %0d 0", n, saw, HOLD); end
        n_cmp++; if (dl_count !== 17'd3) begin n_err++; $display("FAIL dl_count_kept: got %0d want 3", dl_count); end
    endtask

    task automatic test_oversize();
        int n; bit saw;
        ioctl_download = 1'b1;
        tick();
        n_cmp++; if (dl_count !== 17'd0) begin n_err++; $display("FAIL ovs_count_clear: got %0d want 0", dl_count); end
        ioctl_index = 8'd0; ioctl_addr = 25'h10000; ioctl_dout = 8'hAA; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        n_cmp++; if ({ioctl_wait, mem_we} !== 2'b10) begin n_err++; $display("FAIL ovs_no_we: got wait=%b we=%b want 1 0", ioctl_wait, mem_we); end
        tick();
        n_cmp++; if (err_oversize !== 1'b1 || dl_count !== 17'd0) begin n_err++; $display("FAIL ovs_flag: got %b %0d want 1 0", err_oversize, dl_count); end
        ioctl_download = 1'b0;
        tick();
        wait_run(n, saw);
        n_cmp++; if (err_oversize !== 1'b1) begin n_err++; $display("FAIL ovs_sticky: got %b want 1", err_oversize); end
        ioctl_download = 1'b1;
        tick();
        n_cmp++; if (err_oversize !== 1'b0) begin n_err++; $display("FAIL ovs_clear: got %b want 0", err_oversize); end
        ioctl_download = 1'b0;
        tick();
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD) begin n_err++; $display("FAIL ovs_hold: got %0d want %0d", n, HOLD); end
    endtask

    task automatic test_dip_run();
        logic [7:0] v [3];
        v[0] = 8'h80; v[1] = 8'h01; v[2] = 8'h7F;
        cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ioctl_index = 8'd254; ioctl_addr = 25'(i); ioctl_dout = v[i]; ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
            n_cmp++; if ({cpu_reset, mem_addr, mem_wdata, mem_we} !== {1'b0, 16'h1234, 8'h5A, 1'b1})
                begin n_err++; $display("FAIL dip_port%0d: got rst=%b %h %h %b want 0 1234 5a 1", i, cpu_reset, mem_addr, mem_wdata, mem_we); end
            tick();
        end
        n_cmp++; if ({sw0, sw1, sw2} !== 24'h80017F) begin n_err++; $display("FAIL dip_values: got %h want 80017f", {sw0, sw1, sw2}); end
        hps_write(8'd254, 25'd3, 8'h00);
        hps_write(8'd1, 25'd0, 8'h05);
        hps_write(8'd1, 25'd1, 8'h09);
        n_cmp++; if ({mod, sw0, sw1, sw2} !== 32'h0580017F) begin n_err++; $display("FAIL mod_decode: got %h want 0580017f", {mod, sw0, sw1, sw2}); end
        hps_write(8'd0, 25'd0, 8'h11);
        hps_write(8'd0, 25'h10000, 8'h22);
        n_cmp++; if ({dl_count, err_oversize, cpu_reset} !== {17'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL rom_in_run: got %0d %b %b want 0 0 0", dl_count, err_oversize, cpu_reset); end
    endtask

    task automatic test_back_to_back();
        int n; bit saw;
        ioctl_download = 1'b1;
        tick();
        ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        tick();
        ioctl_addr = 25'd1; ioctl_dout = 8'h22;
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 8'h11}) begin n_err++; $display("FAIL b2b_first: got %b %h %h want 1 0000 11", mem_we, mem_addr, mem_wdata); end
        tick();
        ioctl_wr = 1'b0;
        n_cmp++; if ({ioctl_wait, mem_we, err_overrun} !== 3'b001 || dl_count !== 17'd1) begin n_err++; $display("FAIL b2b_drop: got wait=%b we=%b ovr=%b cnt=%0d want 0 0 1 1", ioctl_wait, mem_we, err_overrun, dl_count); end
        ioctl_download = 1'b0;
        tick();
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD || err_overrun !== 1'b1) begin n_err++; $display("FAIL b2b_hold: got %0d ovr=%b want %0d 1", n, err_overrun, HOLD); end
    endtask

    task automatic test_late_commit();
        int n; bit saw;
        ioctl_download = 1'b1;
        tick();
        ioctl_index = 8'd0; ioctl_addr = 25'd5; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0005, 8'h33}) begin n_err++; $display("FAIL late_commit: got %b %h %h want 1 0005 33", mem_we, mem_addr, mem_wdata); end
        tick();
        n_cmp++; if (dl_count !== 17'd1) begin n_err++; $display("FAIL late_count: got %0d want 1", dl_count); end
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD + 1) begin n_err++; $display("FAIL late_hold: got %0d want %0d", n, HOLD + 1); end
    endtask

    task automatic test_reset_mid_load();
        int n; bit saw;
        ioctl_download = 1'b1;
        tick();
        ioctl_index = 8'd0; ioctl_addr = 25'd7; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if ({mem_we, ioctl_wait, cpu_reset} !== 3'b001) begin n_err++; $display("FAIL mid_rst_abort: got we=%b wait=%b rst=%b want 0 0 1", mem_we, ioctl_wait, cpu_reset); end
        tick(); tick();
        reset = 1'b0;
        wait_run(n, saw);
        n_cmp++; if (n !== HOLD || saw !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold: got %0d we=%b want %0d 0", n, saw, HOLD); end
        n_cmp++; if ({dl_count, mem_addr, mem_we} !== {17'd0, 16'h1234, 1'b1}) begin n_err++; $display("FAIL mid_rst_run: got %0d %h %b want 0 1234 1", dl_count, mem_addr, mem_we); end
    endtask

    initial begin
        test_reset();
        test_download();
        test_oversize();
        test_dip_run();
        test_back_to_back();
        test_late_commit();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
